serial_borrow_sub: RTL and testbench
====================================

Name: serial_borrow_sub

Overview:
- Bit-serial ripple-borrow subtractor: computes A − B − Bin one bit per clock, LSB first. It is the subtract-direction counterpart to the adder datapath.
- Operands are accepted through a valid/ready handshake. The result is returned through a second valid/ready handshake.
- Used where area matters more than latency, next to the ripple-carry adder blocks.

Parameters:
- WIDTH, 5, operand and difference width in bits (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a/b/bin are valid.
- in_ready  output  1  block can accept operands (IDLE only).
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  diff/bout are valid (DONE only).
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a − b − bin mod 2^WIDTH.
- bout  output  1  final borrow-out (1 when a < b + bin, unsigned).
- busy  output  1  high in RUN and DONE.

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n). All state is flopped on rising clk.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - diff=0, bout=0, internal borrow=0, bit counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge: capture a, b into shift registers; borrow←bin; count←0; go to RUN.
- RUN:
  - in_ready=0. Each cycle, process bit 0 of the operand shift registers:
    - d = a0 ^ b0 ^ borrow
    - borrow_next = (~a0 & b0) | (~(a0 ^ b0) & borrow)
  - Shift d into diff from the MSB side (diff ← {d, diff[WIDTH-1:1]}). Shift both operand registers right by one.
  - count increments each cycle. On the cycle count==WIDTH-1: bout←borrow_next and go to DONE.
  - Exactly WIDTH RUN cycles.
- DONE:
  - out_valid=1. diff and bout are held stable until out_ready==1 at an edge, then go to IDLE.
  - Result values persist after handshake until the next operation starts shifting.
- Latency: if accept occurs at edge T, out_valid rises after edge T+WIDTH. Minimum issue interval is WIDTH+2 cycles with out_ready tied high.
- Changes to a, b, bin outside the accept edge are ignored.
- in_valid during RUN or DONE: ignored, no capture. The producer must hold in_valid until in_ready.
- out_ready while not in DONE: ignored.
- No overlap: the result handshake and a new accept never occur on the same edge. IDLE is always visited for at least one cycle.
- diff/bout are meaningful only while out_valid=1. During RUN, diff shows partial shift contents.
- Reset asserted mid-RUN or in DONE: immediate return to reset values. The in-flight operation is discarded with no partial out_valid.
- Width rules: all arithmetic is modulo 2^WIDTH. bout is the unsigned borrow.
- Sanity case: WIDTH=1 gives a single RUN cycle.

Decomposition:
- Package serial_borrow_sub_pkg holds the state enum (IDLE, RUN, DONE) and the counter-width constant, $clog2(WIDTH) with a minimum of 1.
- One sub-module: fs (1-bit full subtractor).
  - Inputs: a, b, bin. Outputs: d, bout.
  - Purely combinational, instantiated once in the RUN datapath.
- FSM, counter and shift registers stay in the top module.

Test Plan:
- a=9, b=3, bin=0, out_ready=1 -> out_valid rises 5 cycles after accept; diff=6, bout=0; in_ready returns high one cycle after handshake.
- a=3, b=9, bin=0 -> diff=26, bout=1.
- a=0, b=0, bin=1 -> diff=31, bout=1. Also a=31, b=31, bin=0 -> diff=0, bout=0.
- Hold out_ready=0 for 4 cycles in DONE, pulse in_valid with new operands -> diff/bout/out_valid unchanged, in_ready=0, no capture. Release out_ready -> IDLE, then the new operands are accepted.
- Drop rst_n at the 2nd RUN cycle -> all outputs at reset values immediately (out_valid=0, busy=0, diff=0). After release, a=17, b=5 completes with diff=12, bout=0.
- Randomized back-to-back operands vs. a reference model over 1000 ops with random out_ready stalls -> every diff/bout matches (a−b−bin) mod 32 and the unsigned borrow.

Source files
------------

// File: rtl/serial_borrow_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial borrow subtractor.
package serial_borrow_sub_pkg;

   localparam int unsigned DEFAULT_WIDTH = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit-counter width: $clog2(width), never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_borrow_sub_fs.sv
// One-bit full subtractor: a - b - bin with borrow-out.
module serial_borrow_sub_fs (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference bit and ripple borrow.
   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/serial_borrow_sub.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
module serial_borrow_sub
   import serial_borrow_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               borrow_q, borrow_d;
   logic               bout_q, bout_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               busy_q, busy_d;
   logic               fs_d, fs_bout;

   // Single full subtractor working on the current LSBs.
   serial_borrow_sub_fs u_fs (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (borrow_q),
      .d    (fs_d),
      .bout (fs_bout)
   );

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      diff_d      = diff_q;
      cnt_d       = cnt_q;
      borrow_d    = borrow_q;
      bout_d      = bout_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d      = a;
               b_d      = b;
               borrow_d = bin;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            diff_d   = (diff_q >> 1) | (WIDTH'(fs_d) << (WIDTH - 1));
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            borrow_d = fs_bout;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               bout_d  = fs_bout;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d == RUN) || (state_d == DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         diff_q      <= '0;
         cnt_q       <= '0;
         borrow_q    <= 1'b0;
         bout_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         diff_q      <= diff_d;
         cnt_q       <= cnt_d;
         borrow_q    <= borrow_d;
         bout_q      <= bout_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_serial_borrow_sub.sv
// Self-checking bench for serial_borrow_sub: directed cases plus randomized ops vs. an arithmetic model.
module tb_serial_borrow_sub;

   localparam int unsigned W    = 5;
   localparam int          MASK = (1 << W) - 1;
   localparam int          TMO  = 50;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         bout;
   logic         busy;

   int n_checks = 0;
   int n_pass   = 0;

   serial_borrow_sub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer subtraction, borrow when the true result is negative.
   function automatic int ref_diff(input int av, input int bv, input int cv);
      return (av - bv - cv) & MASK;
   endfunction

   function automatic int ref_bout(input int av, input int bv, input int cv);
      return (av - bv - cv) < 0 ? 1 : 0;
   endfunction

   // Present operands, wait for acceptance, then for the result; check latency and value.
   task automatic start_and_wait(input int av, input int bv, input int cv, input bit rnd_ready);
      int k;
      a        = W'(av);
      b        = W'(bv);
      bin      = cv[0];
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < TMO) begin
         tick();
         k++;
      end
      if (k >= TMO) chk("in_ready_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      bin      = 1'($urandom);
      k = 0;
      while (!out_valid && k < TMO) begin
         if (rnd_ready) out_ready = 1'($urandom);
         tick();
         k++;
      end
      chk("latency", k, W);
      chk("diff", int'(diff), ref_diff(av, bv, cv));
      chk("bout", int'(bout), ref_bout(av, bv, cv));
   endtask

   // Stall for a number of cycles in DONE, then complete the result handshake.
   task automatic finish(input int stall, input bit full);
      logic [W-1:0] d0;
      logic         b0;
      d0 = diff;
      b0 = bout;
      out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         tick();
         if (full) begin
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_diff", int'(diff), int'(d0));
         end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("post_hs_in_ready", int'(in_ready), 1);
      if (full) begin
         chk("post_hs_out_valid", int'(out_valid), 0);
         chk("post_hs_diff_held", int'(diff), int'(d0));
         chk("post_hs_bout_held", int'(bout), int'(b0));
      end
   endtask

   initial begin
      logic [W-1:0] hd;
      logic         hb;
      int ra, rb, rc;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      #12;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_diff", int'(diff), 0);
      chk("rst_bout", int'(bout), 0);
      rst_n = 1'b1;
      tick();

      // Directed arithmetic cases, including wrap and equal-operand boundaries.
      start_and_wait(9, 3, 0, 1'b0);
      chk("busy_done", int'(busy), 1);
      chk("in_ready_done", int'(in_ready), 0);
      finish(0, 1'b1);
      start_and_wait(3, 9, 0, 1'b0);
      finish(1, 1'b1);
      start_and_wait(0, 0, 1, 1'b0);
      finish(0, 1'b1);
      start_and_wait(31, 31, 0, 1'b0);
      finish(0, 1'b1);

      // Hold the result while new operands are offered; they must not be captured.
      start_and_wait(20, 7, 1, 1'b0);
      hd = diff;
      hb = bout;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         a        = W'(1);
         b        = W'(2);
         bin      = 1'b0;
         tick();
         chk("hold_out_valid", int'(out_valid), 1);
         chk("hold_in_ready", int'(in_ready), 0);
         chk("hold_diff", int'(diff), int'(hd));
         chk("hold_bout", int'(bout), int'(hb));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("hold_release_in_ready", int'(in_ready), 1);
      start_and_wait(1, 2, 0, 1'b0);
      finish(0, 1'b1);

      // Reset in the second RUN cycle discards the operation.
      a        = W'(10);
      b        = W'(4);
      bin      = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("pre_rst_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("midrun_rst_out_valid", int'(out_valid), 0);
      chk("midrun_rst_busy", int'(busy), 0);
      chk("midrun_rst_diff", int'(diff), 0);
      chk("midrun_rst_bout", int'(bout), 0);
      chk("midrun_rst_in_ready", int'(in_ready), 1);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_out_valid", int'(out_valid), 0);
      start_and_wait(17, 5, 0, 1'b0);
      finish(0, 1'b1);

      // Randomized back-to-back operations with random output stalls.
      for (int n = 0; n < 1000; n++) begin
         ra = int'($urandom_range(0, MASK));
         rb = int'($urandom_range(0, MASK));
         rc = int'($urandom_range(0, 1));
         start_and_wait(ra, rb, rc, 1'b1);
         finish(int'($urandom_range(0, 3)), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
